// File: rtl/histo_pkg.sv
// Shared definitions for the histogram output path: default widths and the
// stream transmitter FSM encoding.
package histo_pkg;

  localparam int P_DW    = 16;
  localparam int P_NBINS = 256;
  localparam int P_AW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } tx_state_e;

endpackage

// File: rtl/axis_tx_buf.sv
// Two-entry FIFO holding {tlast, data} words for an AXI-Stream master.
// Push and pop may happen together at any occupancy; a pop on an empty
// buffer is ignored.
module axis_tx_buf #(
  parameter int P_W = 17
) (
  input  logic           aclk,
  input  logic           areset_n,
  input  logic           push,
  input  logic [P_W-1:0] push_data,
  input  logic           pop,
  output logic [1:0]     occupancy,
  output logic           not_empty,
  output logic [P_W-1:0] head
);

  logic [P_W-1:0] mem_q [2];
  logic [P_W-1:0] mem_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           pop_ok;

  assign pop_ok    = pop && (count_q != 2'd0);
  assign occupancy = count_q;
  assign not_empty = (count_q != 2'd0);
  assign head      = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.  When full, a push lands
  // in the slot being popped this cycle, which becomes the new tail.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_stream_tx.sv
// Streams histogram bin counts 0..P_NBINS-1 out as AXI-Stream beats, reading
// the bin RAM through a 1-cycle-latency port and buffering in axis_tx_buf.
// Optional macro AXI_STREAM_TX_READ_CLEAR_EN: write 0 back to each bin as its
// read datum lands, leaving the histogram cleared for the next frame.
module axi_stream_tx #(
  parameter int P_DW    = histo_pkg::P_DW,
  parameter int P_NBINS = histo_pkg::P_NBINS,
  parameter int P_AW    = histo_pkg::P_AW
) (
  input  logic            aclk,
  input  logic            areset_n,
  input  logic            start,
  output logic            bin_rd_en,
  output logic [P_AW-1:0] bin_rd_addr,
  input  logic [P_DW-1:0] bin_rd_data,
`ifdef AXI_STREAM_TX_READ_CLEAR_EN
  output logic            bin_wr_en,
  output logic [P_AW-1:0] bin_wr_addr,
  output logic [P_DW-1:0] bin_wr_data,
`endif
  output logic [P_DW-1:0] tdata,
  output logic            tvalid,
  output logic            tlast,
  input  logic            tready,
  output logic            tx_busy,
  output logic            tx_done
);

  import histo_pkg::*;

  tx_state_e       state_q, state_d;
  logic [P_AW-1:0] addr_q, addr_d;
  logic            rd_en_q, rd_en_d;      // a read is in flight this cycle
  logic            rd_last_q, rd_last_d;  // the in-flight read is the final bin
  logic            tx_busy_q, tx_busy_d;
  logic            tx_done_q, tx_done_d;

  logic [1:0]      buf_occ;
  logic            buf_valid;
  logic [P_DW:0]   buf_head;
  logic            pop;
  logic [2:0]      credit_used;
  logic            issue;
  logic            last_addr;

  assign pop       = buf_valid && tready;
  assign last_addr = (addr_q == P_AW'(P_NBINS - 1));

  // A beat leaving this cycle frees its slot in time for a read issued now,
  // which is what allows one beat per cycle with tready held high.
  assign credit_used = {1'b0, buf_occ} + {2'b0, rd_en_q} - {2'b0, pop};
  assign issue       = (state_q == READ) && (credit_used < 3'd2);

  assign bin_rd_en   = issue;
  assign bin_rd_addr = addr_q;

  assign tvalid  = buf_valid;
  assign tdata   = buf_head[P_DW-1:0];
  assign tlast   = buf_valid && buf_head[P_DW];
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  axis_tx_buf #(
    .P_W (P_DW + 1)
  ) u_buf (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .push      (rd_en_q),
    .push_data ({rd_last_q, bin_rd_data}),
    .pop       (pop),
    .occupancy (buf_occ),
    .not_empty (buf_valid),
    .head      (buf_head)
  );

  // FSM next-state, address counter and registered status outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_busy_d = tx_busy_q;
    tx_done_d = 1'b0;
    rd_en_d   = issue;
    rd_last_d = issue && last_addr;
    case (state_q)
      IDLE: begin
        // A start coinciding with tx_done belongs to the finished frame.
        if (start && !tx_done_q) begin
          state_d   = READ;
          tx_busy_d = 1'b1;
          addr_d    = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (last_addr) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // The tagged beat is the last word ever pushed, so popping it leaves
        // the buffer empty with nothing in flight.
        if (pop && buf_head[P_DW]) begin
          state_d   = IDLE;
          tx_busy_d = 1'b0;
          tx_done_d = 1'b1;
          addr_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Control registers, cleared asynchronously so a mid-frame reset abandons
  // the frame at once.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_last_q <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      rd_last_q <= rd_last_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

`ifdef AXI_STREAM_TX_READ_CLEAR_EN
  logic [P_AW-1:0] rd_addr_q;

  // Remember the address of the in-flight read so it can be zeroed as the
  // datum lands.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= addr_q;
    end
  end

  assign bin_wr_en   = rd_en_q;
  assign bin_wr_addr = rd_addr_q;
  assign bin_wr_data = '0;
`endif

endmodule

// File: doc/axi_stream_tx.md
Name: axi_stream_tx

Overview:
- Streams the finished histogram bin counts out of the histogram block as an AXI-Stream master.
- On a start pulse it reads bin RAM addresses 0..P_NBINS-1 through a 1-cycle-latency read port.
- Each bin count becomes one beat; tlast is asserted on the final bin.
- Sits at the output end of the histogram pipeline, mirroring the receive path on the input side.

Parameters:
- P_DW, 16, bin count width and tdata width.
- P_NBINS, 256, number of bins streamed per frame (must be ≥2).
- P_AW, 8, bin address width; must satisfy 2**P_AW ≥ P_NBINS.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse requesting one frame; ignored while tx_busy=1.
- bin_rd_en  out  1  bin RAM read strobe.
- bin_rd_addr  out  P_AW  bin RAM read address.
- bin_rd_data  in  P_DW  bin RAM data, valid exactly 1 cycle after bin_rd_en.
- tdata  out  P_DW  stream data.
- tvalid  out  1  stream valid.
- tlast  out  1  high on the beat carrying bin P_NBINS-1.
- tready  in  1  downstream ready.
- tx_busy  out  1  high from the cycle after an accepted start until the final beat handshakes.
- tx_done  out  1  one-cycle pulse, the cycle after the tlast beat handshakes.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, address counter 0, buffer empty.
- FSM states:
  - IDLE: start=1 -> READ, tx_busy=1 next cycle.
  - READ: issues reads. After issuing address P_NBINS-1 -> DRAIN.
  - DRAIN: no reads issued. Buffer empty and no read in flight -> IDLE, with tx_done pulsed that cycle.
- Read issue rule: bin_rd_en=1 in READ iff (buffer occupancy + in-flight reads) < 2.
  - bin_rd_addr increments by 1 after each issued read.
  - No reads are ever issued past P_NBINS-1.
- Read data lands in a 2-entry FIFO output buffer one cycle after bin_rd_en. Overflow is impossible by the credit rule above.
- tvalid equals buffer not empty; tdata and tlast come from the buffer head.
- tlast is carried as a tag bit alongside the data for address P_NBINS-1.
- A beat transfers when tvalid && tready; the head is popped that cycle.
  - Simultaneous push and pop is allowed at any occupancy.
- AXI rules:
  - Once tvalid is high, tvalid, tdata and tlast hold stable until the handshake.
  - tvalid must never depend combinationally on tready.
- Throughput: one beat per cycle sustained with tready held high.
  - First beat appears on tvalid 3 cycles after start: cycle 1 READ issue, cycle 2 data pushed, cycle 3 tvalid.
  - tready low stalls reads within 2 beats; no data is lost.
- start is ignored unless in IDLE. A start in the same cycle as tx_done is ignored; restart requires IDLE.
- Asynchronous reset mid-frame:
  - Immediately clears the FSM, counter, buffer, tvalid and tlast.
  - The partial frame is abandoned with no tlast; downstream must reset too.
- Address arithmetic is unsigned. The counter never wraps inside a frame and returns to 0 on entering IDLE.

Optional Feature:
- Macro: AXI_STREAM_TX_READ_CLEAR_EN.
- When defined:
  - Adds output ports bin_wr_en (1), bin_wr_addr (P_AW) and bin_wr_data (P_DW).
  - In the cycle each read datum lands, the module writes 0 to that same address, leaving the histogram cleared for the next frame.
  - bin_wr_data is tied to 0.
- When undefined: no write ports exist, and the RAM contents are untouched.

Decomposition:
- Package histo_pkg holds:
  - the default widths P_DW, P_NBINS and P_AW;
  - the FSM state encoding (IDLE=2'd0, READ=2'd1, DRAIN=2'd2).
- Natural sub-module axis_tx_buf: a 2-entry FIFO of {tlast, data} with push, pop, occupancy, head outputs and async reset.
  - Reusable for other stream masters.

Test Plan:
- P_NBINS=4, bin RAM = {5,6,7,8}, tready=1, start pulse -> beats 5,6,7,8 on consecutive cycles starting 3 cycles after start; tlast only on 8; tx_done 1 cycle after beat 8.
- Same data, tready toggling 1,0,0,1 repeating -> identical sequence 5,6,7,8; tdata/tvalid stable during every stall; bin_rd_en never exceeds 2 outstanding.
- tready=0 for 20 cycles after start -> exactly 2 reads issued, tvalid held with tdata=5; release tready -> remaining beats delivered in order.
- start re-pulsed at cycle 2 of a frame -> ignored; exactly 4 beats and a single tx_done.
- areset_n low while beat 2 is pending -> tvalid, tlast, tx_busy = 0 immediately; a new start after release produces a full 4-beat frame from address 0.
- With AXI_STREAM_TX_READ_CLEAR_EN: after one frame, bin RAM reads all 0; a second frame streams 0,0,0,0 with tlast on the 4th beat.
